// File: rtl/instr_mem_loader.sv
// Byte-stream instruction loader: header N (LE16), then N little-endian words written to imem.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CHK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERROR} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        in_ready_q, in_ready_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] wl_q, wl_d;
    logic [15:0] hdr_n;
    logic        accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    assign accept = in_valid && in_ready_q;
    assign hdr_n  = {in_data, n_q[7:0]};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            HDR_LO: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    n_d[15:8] = in_data;
                    if (hdr_n == 16'd0 || hdr_n > MAX_W) state_d = ERROR;
                    else                                 state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    cnt_d   = cnt_q + 2'd1;
                    shift_d = {in_data, shift_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ in_data;
`endif
                    // Fourth byte: strobe lands next cycle, address uses the pre-increment count
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {in_data, shift_q};
                        addr_d  = {46'd0, wl_q, 2'b00};
                        wl_d    = wl_q + 16'd1;
                        if (wl_q + 16'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_d = (in_data == chk_q) ? DONE : ERROR;
            end
`endif
            default: ;
        endcase
        in_ready_d  = !(state_d == DONE || state_d == ERROR);
        cpu_reset_d = (state_d != DONE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR_LO;
            n_q         <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wl_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wl_q        <= wl_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes queued by stimulus, checked by a monitor.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    instr_mem_loader #(.MAX_WORDS(64)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_t e;
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got 0x%0h@0x%0h expected 0x%0h@0x%0h",
                             imem_wdata, imem_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        in_data  = b;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        if (gap) tick(1);
    endtask

    task automatic send_chk(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send(b, 1'b0);
`else
        if (b == 8'hFF) in_data = b;
`endif
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic expect_wr(input logic [63:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_stream32(input bit gap);
        logic [7:0] s [10];
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        expect_wr(64'h0, 32'h00A00513);
        expect_wr(64'h4, 32'h00500593);
        for (int i = 0; i < 10; i++) send(s[i], gap);
        send_chk(8'h70);
        tick(2);
    endtask

    initial begin
        int base;
        logic [63:0] addr_s;
        logic [31:0] data_s;

        tick(1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", imem_addr, 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_flags", {62'd0, load_done, load_err}, 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b0;
        tick(1);

        // Back-to-back two-word load
        send_stream32(1'b0);
        check("b2b_words", 64'(words_loaded), 64'd2);
        check("b2b_done", 64'(load_done), 64'd1);
        check("b2b_cpu_reset", 64'(cpu_reset), 64'd0);
        check("b2b_in_ready", 64'(in_ready), 64'd0);
        check("b2b_err", 64'(load_err), 64'd0);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Extra bytes after DONE are ignored and outputs hold
        base   = we_cnt;
        addr_s = imem_addr;
        data_s = imem_wdata;
        for (int i = 0; i < 6; i++) send(8'hC3 + 8'(i), 1'b0);
        tick(2);
        check("post_done_we", 64'(we_cnt - base), 64'd0);
        check("post_done_addr", imem_addr, addr_s);
        check("post_done_wdata", 64'(imem_wdata), 64'(data_s));
        check("post_done_state", {60'd0, in_ready, load_done, cpu_reset, load_err}, 64'b0100);
        check("post_done_words", 64'(words_loaded), 64'd2);

        // Same stream with an idle cycle between bytes
        do_reset();
        base = we_cnt;
        send_stream32(1'b1);
        check("gap_pulses", 64'(we_cnt - base), 64'd2);
        check("gap_words", 64'(words_loaded), 64'd2);
        check("gap_done", 64'(load_done), 64'd1);

        // Zero-length header
        do_reset();
        base = we_cnt;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        tick(3);
        check("n0_state", {60'd0, load_err, cpu_reset, in_ready, load_done}, 64'b1100);
        check("n0_pulses", 64'(we_cnt - base), 64'd0);

        // Header one beyond capacity
        do_reset();
        send(8'h41, 1'b0);
        send(8'h00, 1'b0);
        send(8'h13, 1'b0);
        tick(3);
        check("n65_state", {60'd0, load_err, cpu_reset, in_ready, load_done}, 64'b1100);
        check("n65_pulses", 64'(we_cnt - base), 64'd0);

        // Header exactly at capacity is accepted
        do_reset();
        send(8'h40, 1'b0);
        send(8'h00, 1'b0);
        tick(1);
        check("n64_accept", {62'd0, in_ready, load_err}, 64'b10);

        // Reset after six data bytes, then a fresh one-word load
        do_reset();
        expect_wr(64'h0, 32'h00A00513);
        begin
            logic [7:0] s [8];
            s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
            for (int i = 0; i < 8; i++) send(s[i], 1'b0);
        end
        do_reset();
        check("abort_words", 64'(words_loaded), 64'd0);
        check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        base = we_cnt;
        expect_wr(64'h0, 32'h00000013);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send_chk(8'h13);
        tick(2);
        check("reload_pulses", 64'(we_cnt - base), 64'd1);
        check("reload_words", 64'(words_loaded), 64'd1);
        check("reload_done", 64'(load_done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        expect_wr(64'h0, 32'h00A00513);
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'hA0, 1'b0); send(8'h00, 1'b0);
        send(8'hB6, 1'b0);
        tick(2);
        check("chk_ok", {62'd0, load_done, load_err}, 64'b10);
        do_reset();
        expect_wr(64'h0, 32'h00A00513);
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'hA0, 1'b0); send(8'h00, 1'b0);
        send(8'hB7, 1'b0);
        tick(2);
        check("chk_bad", {61'd0, load_done, load_err, cpu_reset}, 64'b011);
`endif

        tick(2);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
